fane_mac_driver: RTL and testbench

Initiator-side sequencer for one fane_mac unit. It accepts a dot-product job (bias and vector length) and a valid/ready stream of FP8 operand pairs. For each pair it drives mul_a, mul_b, cascade_sum_in and the clock enables. The first pair uses the bias as cascade input; every later pair feeds back the captured acc_out, and the final accumulation is returned on a valid/ready result port. It sits between the operand buffers and the fane_mac array; the block is the driving end of the MAC interface.

---
 rtl/fane_pkg.sv | 18 +
 rtl/fane_mac_driver_if.sv | 40 ++++
 rtl/fane_mac_beat_timer.sv | 28 ++
 rtl/fane_mac_driver.sv | 131 +++++++++++++
 tb/tb_fane_mac_driver.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fane_pkg.sv
// fane_pkg: shared FP8 constants, driver state encoding and format check.
// Imported by the fane_mac driver and the fane_mac datapath.
package fane_pkg;

  localparam int FP8_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  function automatic bit fmt_ok(input int exp_w, input int mant_w);
    return (exp_w + mant_w + 1) == FP8_W;
  endfunction

endpackage

// File: rtl/fane_mac_driver_if.sv
// fane_mac_driver_if: bus between the driver and one fane_mac unit.
// master = driver end, slave = fane_mac end.
interface fane_mac_driver_if;
  import fane_pkg::*;

  logic             mac_ce;
  logic             mac_ce_a_1;
  logic             mac_ce_a_2;
  logic             mac_ce_b_1;
  logic             mac_ce_b_2;
  logic [FP8_W-1:0] mac_a;
  logic [FP8_W-1:0] mac_b;
  logic [FP8_W-1:0] mac_cascade_sum_in;
  logic [FP8_W-1:0] mac_acc_out;

  modport master (
    output mac_ce,
    output mac_ce_a_1,
    output mac_ce_a_2,
    output mac_ce_b_1,
    output mac_ce_b_2,
    output mac_a,
    output mac_b,
    output mac_cascade_sum_in,
    input  mac_acc_out
  );

  modport slave (
    input  mac_ce,
    input  mac_ce_a_1,
    input  mac_ce_a_2,
    input  mac_ce_b_1,
    input  mac_ce_b_2,
    input  mac_a,
    input  mac_b,
    input  mac_cascade_sum_in,
    output mac_acc_out
  );

endinterface

// File: rtl/fane_mac_beat_timer.sv
// fane_mac_beat_timer: loadable down-counter timing one MAC beat.
// Loads MAC_LAT-1, counts down while dec is high, stops at zero.
module fane_mac_beat_timer #(
  parameter int MAC_LAT = 4,
  localparam int W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(MAC_LAT - 1);
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fane_mac_driver.sv
// fane_mac_driver: sequences one dot-product job through a fane_mac,
// chaining acc_out back into cascade_sum_in beat by beat.
module fane_mac_driver
  import fane_pkg::*;
#(
  parameter int EXP_WIDTH  = 2,
  parameter int MANT_WIDTH = 5,
  parameter int MAC_LAT    = 4,
  parameter int LEN_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [FP8_W-1:0] bias,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [FP8_W-1:0] op_a,
  input  logic [FP8_W-1:0] op_b,
  fane_mac_driver_if.master mac,
  output logic             res_valid,
  output logic [FP8_W-1:0] res_data,
  input  logic             res_ready,
  output logic             busy
);

  if (!fmt_ok(EXP_WIDTH, MANT_WIDTH) || MAC_LAT < 1) begin : g_bad_cfg
    $error("fane_mac_driver: illegal FP8 format or MAC_LAT");
  end

  state_t           state;
  logic [FP8_W-1:0] partial;
  logic [LEN_W-1:0] remaining;
  logic             ce_q;
  logic [FP8_W-1:0] a_q;
  logic [FP8_W-1:0] b_q;
  logic [FP8_W-1:0] casc_q;
  logic             t_load;
  logic             t_zero;

  assign t_load = (state == ISSUE) && op_valid && op_ready;

  fane_mac_beat_timer #(
    .MAC_LAT(MAC_LAT)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (t_load),
    .dec  (state == WAIT),
    .zero (t_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      partial   <= '0;
      remaining <= '0;
      ce_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      casc_q    <= '0;
      op_ready  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            partial   <= bias;
            remaining <= vec_len;
            busy      <= 1'b1;
            if (vec_len == '0) begin
              res_data <= bias;
              state    <= DONE;
            end else begin
              op_ready <= 1'b1;
              ce_q     <= 1'b1;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (op_valid) begin
            a_q      <= op_a;
            b_q      <= op_b;
            casc_q   <= partial;
            op_ready <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (t_zero) begin
            partial   <= mac.mac_acc_out;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) begin
              res_data  <= mac.mac_acc_out;
              res_valid <= 1'b1;
              ce_q      <= 1'b0;
              state     <= DONE;
            end else begin
              op_ready <= 1'b1;
              state    <= ISSUE;
            end
          end
        end
        DONE: begin
          // empty jobs arrive here with res_valid still low
          if (!res_valid) begin
            res_valid <= 1'b1;
          end else if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mac.mac_ce             = ce_q;
  assign mac.mac_ce_a_1         = ce_q;
  assign mac.mac_ce_a_2         = ce_q;
  assign mac.mac_ce_b_1         = ce_q;
  assign mac.mac_ce_b_2         = ce_q;
  assign mac.mac_a              = a_q;
  assign mac.mac_b              = b_q;
  assign mac.mac_cascade_sum_in = casc_q;

endmodule

// File: tb/tb_fane_mac_driver.sv
// tb_fane_mac_driver: directed jobs against a stub MAC (acc = cascade+1),
// checked every cycle against an edge-timed behavioural model.
module tb_fane_mac_driver;
  import fane_pkg::*;

  localparam int MAC_LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] bias = '0;
  logic [7:0] vec_len = '0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [7:0] op_a = '0;
  logic [7:0] op_b = '0;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_ready = 1'b0;
  logic       busy;

  fane_mac_driver_if mif ();

  fane_mac_driver #(
    .EXP_WIDTH (2),
    .MANT_WIDTH(5),
    .MAC_LAT   (MAC_LAT),
    .LEN_W     (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bias     (bias),
    .vec_len  (vec_len),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .mac      (mif),
    .res_valid(res_valid),
    .res_data (res_data),
    .res_ready(res_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // stub MAC: three stages after the driver's input register = MAC_LAT
  logic [7:0] pipe [3];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe[0] <= '0;
      pipe[1] <= '0;
      pipe[2] <= '0;
    end else if (mif.mac_ce) begin
      pipe[0] <= mif.mac_cascade_sum_in + 8'd1;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
  end
  assign mif.mac_acc_out = pipe[2];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int cmp = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)",
               name, act, exp, cyc);
    end
  endtask

  // model state, valid between edges
  logic       m_busy, m_ready, m_ce, m_rv;
  logic [7:0] m_rd, m_a, m_b, m_casc, m_acc;
  int         m_rem, m_cap, m_post, m_t0;
  int         hs_rel [8];
  logic [7:0] hs_casc [8];
  int         hs_n;
  int         res_edge;
  logic [7:0] res_val;
  logic       ce_any, rdy_any;

  task automatic model_clear();
    m_busy = 0; m_ready = 0; m_ce = 0; m_rv = 0;
    m_rd = 0; m_a = 0; m_b = 0; m_casc = 0; m_acc = 0;
    m_rem = 0; m_cap = -1; m_post = -1;
  endtask

  initial begin
    model_clear();
    m_t0 = 0; hs_n = 0; res_edge = -1; res_val = 0;
    ce_any = 0; rdy_any = 0;
  end

  logic [4:0] ces;
  assign ces = {mif.mac_ce, mif.mac_ce_a_1, mif.mac_ce_a_2,
                mif.mac_ce_b_1, mif.mac_ce_b_2};

  always @(negedge clk) begin
    int n;
    if (!rst_n) begin
      chk("rst op_ready", 32'(op_ready), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst res_valid", 32'(res_valid), 0);
      chk("rst res_data", 32'(res_data), 0);
      chk("rst ce", 32'(ces), 0);
      chk("rst mac_a", 32'(mif.mac_a), 0);
      chk("rst mac_b", 32'(mif.mac_b), 0);
      chk("rst casc", 32'(mif.mac_cascade_sum_in), 0);
      model_clear();
    end else begin
      if (mif.mac_ce) ce_any = 1;
      if (op_ready) rdy_any = 1;
      chk("res_valid", 32'(res_valid), 32'(m_rv));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("op_ready", 32'(op_ready), 32'(m_ready));
      chk("ce", 32'(ces), m_ce ? 32'h1f : 32'h0);
      if (m_rv) chk("res_data", 32'(res_data), 32'(m_rd));
      if (m_ce) begin
        chk("mac_a", 32'(mif.mac_a), 32'(m_a));
        chk("mac_b", 32'(mif.mac_b), 32'(m_b));
        chk("casc", 32'(mif.mac_cascade_sum_in), 32'(m_casc));
      end
      // advance model to the coming edge n
      n = cyc + 1;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_t0 = n; m_acc = bias; m_rem = int'(vec_len);
          hs_n = 0; res_edge = -1;
          if (vec_len == 0) begin
            m_rd = bias; m_post = n + 1;
          end else begin
            m_ce = 1; m_ready = 1;
          end
        end
      end else if (m_rv) begin
        if (res_ready) begin
          m_rv = 0; m_busy = 0;
        end
      end else if (m_ready) begin
        if (op_valid) begin
          m_ready = 0; m_a = op_a; m_b = op_b; m_casc = m_acc;
          m_cap = n + MAC_LAT;
          if (hs_n < 8) begin
            hs_rel[hs_n] = n - m_t0;
            hs_casc[hs_n] = m_acc;
          end
          hs_n++;
        end
      end else if (m_rem == 0) begin
        if (n == m_post) begin
          m_rv = 1; res_edge = n - m_t0; res_val = m_rd;
        end
      end else if (n == m_cap) begin
        m_acc = m_casc + 8'd1;
        m_rem--;
        if (m_rem == 0) begin
          m_rv = 1; m_rd = m_acc; m_ce = 0;
          res_edge = n - m_t0; res_val = m_acc;
        end else begin
          m_ready = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] b, input logic [7:0] l);
    ce_any = 0; rdy_any = 0;
    start = 1; bias = b; vec_len = l;
    tick();
    start = 0;
  endtask

  task automatic wait_rv(input int lim);
    int k = 0;
    while (!res_valid && k < lim) begin
      tick();
      k++;
    end
    if (!res_valid) chk("res_valid timeout", 0, 1);
  endtask

  task automatic take_result();
    res_ready = 1;
    tick();
    res_ready = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    tick();

    // 1: three back-to-back pairs
    op_valid = 1; op_a = 8'h20; op_b = 8'h20;
    start_job(8'h20, 8'd3);
    wait_rv(100);
    chk("t1 hs count", hs_n, 3);
    chk("t1 hs0 edge", hs_rel[0], 1);
    chk("t1 hs1 edge", hs_rel[1], 6);
    chk("t1 hs2 edge", hs_rel[2], 11);
    chk("t1 res edge", res_edge, 15);
    chk("t1 model data", 32'(res_val), 32'h23);
    chk("t1 dut data", 32'(res_data), 32'h23);
    take_result();
    chk("t1 idle busy", 32'(busy), 0);

    // 2: empty job
    op_valid = 0;
    start_job(8'h41, 8'd0);
    wait_rv(20);
    chk("t2 res edge", res_edge, 1);
    chk("t2 data", 32'(res_data), 32'h41);
    chk("t2 hs count", hs_n, 0);
    chk("t2 ce seen", 32'(ce_any), 0);
    chk("t2 op_ready seen", 32'(rdy_any), 0);
    take_result();

    // 3: seven-cycle operand gap before the second pair
    op_valid = 1; op_a = 8'h11; op_b = 8'h22;
    start_job(8'h20, 8'd3);
    while (cyc - m_t0 < 5) tick();
    op_valid = 0; op_a = 8'h55; op_b = 8'h66;
    repeat (7) tick();
    op_a = 8'h33; op_b = 8'h44; op_valid = 1;
    wait_rv(200);
    chk("t3 hs1 edge", hs_rel[1], 13);
    chk("t3 hs2 edge", hs_rel[2], 18);
    chk("t3 res edge", res_edge, 22);
    chk("t3 data", 32'(res_data), 32'h23);
    take_result();

    // 4: consumer stalls in DONE, stray start ignored
    start_job(8'h30, 8'd1);
    wait_rv(50);
    chk("t4 res edge", res_edge, 5);
    chk("t4 data", 32'(res_val), 32'h31);
    repeat (4) tick();
    start = 1; bias = 8'h77; vec_len = 8'd0;
    tick();
    start = 0;
    repeat (5) tick();
    chk("t4 held valid", 32'(res_valid), 1);
    chk("t4 held data", 32'(res_data), 32'h31);
    chk("t4 held ce", 32'(ces), 0);
    take_result();
    chk("t4 released", 32'(busy), 0);
    repeat (3) tick();
    chk("t4 stray start", 32'(busy), 0);

    // 5: async reset during beat 2, then a fresh job
    start_job(8'h20, 8'd3);
    begin
      int k = 0;
      while (hs_n < 2 && k < 100) begin
        tick();
        k++;
      end
    end
    chk("t5 reached beat 2", hs_n, 2);
    tick(); tick();
    #2 rst_n = 0;
    #1;
    chk("t5 async busy", 32'(busy), 0);
    chk("t5 async ce", 32'(ces), 0);
    chk("t5 async casc", 32'(mif.mac_cascade_sum_in), 0);
    chk("t5 async mac_a", 32'(mif.mac_a), 0);
    @(posedge clk);
    #1 rst_n = 1;
    tick();
    start_job(8'h10, 8'd1);
    wait_rv(50);
    chk("t5 res edge", res_edge, 5);
    chk("t5 data", 32'(res_data), 32'h11);
    take_result();

    // 6: cascade wraps past 0xFF
    op_a = 8'h01; op_b = 8'h02;
    start_job(8'hff, 8'd2);
    wait_rv(50);
    chk("t6 casc0", 32'(hs_casc[0]), 32'hff);
    chk("t6 casc1", 32'(hs_casc[1]), 32'h00);
    chk("t6 res edge", res_edge, 10);
    chk("t6 data", 32'(res_data), 32'h01);
    take_result();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
